// File: rtl/gpu_pkg.sv
// gpu_pkg: types and constants shared by the vertex dispatch front end.
//   dispatch_state_t : dispatcher FSM states
//   CFG_*            : host configuration address map
//   TRI_WORDS        : 32-bit words per triangle record
package gpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ISSUE = 2'd2
  } dispatch_state_t;

  localparam logic [4:0] CFG_MAT0   = 5'd0;
  localparam logic [4:0] CFG_LIGHT0 = 5'd16;
  localparam logic [4:0] CFG_BASE   = 5'd19;
  localparam logic [4:0] CFG_COUNT  = 5'd20;
  localparam logic [4:0] CFG_START  = 5'd21;
  localparam logic [4:0] CFG_ABORT  = 5'd22;

  localparam int TRI_WORDS   = 15;
  localparam int MAT_WORDS   = 16;
  localparam int LIGHT_WORDS = 3;

  // Index of the final word of a triangle record.
  localparam logic [3:0] LAST_WORD = 4'd14;

  // True for addresses that name a storage register (matrix, lighting,
  // base, count) rather than a command.
  function automatic logic is_cfg_reg(input logic [4:0] addr);
    return (addr <= CFG_COUNT);
  endfunction

endpackage

// File: rtl/dispatch_cfg_regs.sv
// dispatch_cfg_regs: host-written register file for the vertex dispatcher.
// Writes are locked out while the dispatcher is busy, so the matrix and
// lighting vector stay constant for a whole frame.
// Ports:
//   clock, reset        : clock and asynchronous active-high reset
//   cfg_we/addr/wdata   : host write port
//   busy                : dispatcher not idle (write lock)
//   mat, lighting       : Q16.16 transform matrix and light vector
//   base, count         : triangle base word address and triangle count
module dispatch_cfg_regs
  import gpu_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int CNT_W  = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             cfg_we,
  input  logic [4:0]                       cfg_addr,
  input  logic [31:0]                      cfg_wdata,
  input  logic                             busy,
  output logic [MAT_WORDS-1:0][31:0]       mat,
  output logic [LIGHT_WORDS-1:0][31:0]     lighting,
  output logic [ADDR_W-1:0]                base,
  output logic [CNT_W-1:0]                 count
);

  logic wr_ok;
  assign wr_ok = cfg_we && !busy && is_cfg_reg(cfg_addr);

  // Register file update; ignored while a frame is in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mat      <= '0;
      lighting <= '0;
      base     <= '0;
      count    <= '0;
    end else if (wr_ok) begin
      case (cfg_addr)
        CFG_LIGHT0:          lighting[0] <= cfg_wdata;
        CFG_LIGHT0 + 5'd1:   lighting[1] <= cfg_wdata;
        CFG_LIGHT0 + 5'd2:   lighting[2] <= cfg_wdata;
        CFG_BASE:            base        <= cfg_wdata[ADDR_W-1:0];
        CFG_COUNT:           count       <= cfg_wdata[CNT_W-1:0];
        // Remaining storage addresses are 0..15, the matrix.
        default:             mat[cfg_addr[3:0]] <= cfg_wdata;
      endcase
    end
  end

endmodule

// File: rtl/vertex_dispatch.sv
// vertex_dispatch: fetches 15-word triangle records from triangle memory
// and presents them to vertex_calc under a valid/ready handshake.
// Ports:
//   clock, reset              : clock and asynchronous active-high reset
//   cfg_we/addr/wdata         : host config writes (regs, start, abort)
//   mem_rd, mem_addr          : triangle-memory read request
//   mem_rdata                 : read data, valid one cycle after mem_rd
//   mat, lighting             : config outputs (Q16.16)
//   v_out, color_out1..3      : current triangle record and its colours
//   tri_valid, tri_last       : triangle present / last of frame
//   tri_ready                 : downstream accepts the triangle
//   busy, frame_done          : not idle / one-cycle completion pulse
module vertex_dispatch
  import gpu_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int CNT_W  = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           cfg_we,
  input  logic [4:0]                     cfg_addr,
  input  logic [31:0]                    cfg_wdata,
  output logic                           mem_rd,
  output logic [ADDR_W-1:0]              mem_addr,
  input  logic [31:0]                    mem_rdata,
  output logic [MAT_WORDS-1:0][31:0]     mat,
  output logic [LIGHT_WORDS-1:0][31:0]   lighting,
  output logic [TRI_WORDS-1:0][31:0]     v_out,
  output logic [23:0]                    color_out1,
  output logic [23:0]                    color_out2,
  output logic [23:0]                    color_out3,
  output logic                           tri_valid,
  output logic                           tri_last,
  input  logic                           tri_ready,
  output logic                           busy,
  output logic                           frame_done
);

  dispatch_state_t     state;
  logic [ADDR_W-1:0]   base;
  logic [CNT_W-1:0]    count;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]    remaining;
  logic [3:0]          req_idx;
  // Tracks the request whose data arrives on mem_rdata this cycle.
  logic                pend_valid;
  logic [3:0]          pend_idx;

  logic start_cmd;
  logic abort_cmd;
  logic accept;

  assign start_cmd = cfg_we && (cfg_addr == CFG_START);
  assign abort_cmd = cfg_we && (cfg_addr == CFG_ABORT);
  assign accept    = tri_valid && tri_ready;

  assign color_out1 = v_out[3][23:0];
  assign color_out2 = v_out[7][23:0];
  assign color_out3 = v_out[11][23:0];

  dispatch_cfg_regs #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_cfg (
    .clock     (clock),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .busy      (busy),
    .mat       (mat),
    .lighting  (lighting),
    .base      (base),
    .count     (count)
  );

  // Dispatcher FSM: request issue, response capture and handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      remaining  <= '0;
      req_idx    <= 4'd0;
      pend_valid <= 1'b0;
      pend_idx   <= 4'd0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      v_out      <= '0;
      tri_valid  <= 1'b0;
      tri_last   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      pend_valid <= mem_rd;
      pend_idx   <= req_idx;

      // A response arriving in the abort cycle belongs to the dead frame.
      if (pend_valid && !abort_cmd) begin
        v_out[pend_idx] <= mem_rdata;
      end

      if (abort_cmd) begin
        state      <= IDLE;
        busy       <= 1'b0;
        mem_rd     <= 1'b0;
        tri_valid  <= 1'b0;
        tri_last   <= 1'b0;
        pend_valid <= 1'b0;
        req_idx    <= 4'd0;
      end else begin
        case (state)
          IDLE: begin
            if (start_cmd) begin
              rd_ptr    <= base;
              remaining <= count;
              if (count != '0) begin
                state    <= LOAD;
                busy     <= 1'b1;
                mem_rd   <= 1'b1;
                mem_addr <= base;
                req_idx  <= 4'd0;
              end else begin
                frame_done <= 1'b1;
              end
            end
          end

          LOAD: begin
            if (mem_rd) begin
              if (req_idx == LAST_WORD) begin
                mem_rd <= 1'b0;
                // Next record starts right after this one.
                rd_ptr <= rd_ptr + ADDR_W'(TRI_WORDS);
              end else begin
                req_idx  <= req_idx + 4'd1;
                mem_addr <= mem_addr + ADDR_W'(1'b1);
              end
            end
            if (pend_valid && (pend_idx == LAST_WORD)) begin
              state     <= ISSUE;
              tri_valid <= 1'b1;
              tri_last  <= (remaining == CNT_W'(1'b1));
            end
          end

          ISSUE: begin
            if (accept) begin
              tri_valid <= 1'b0;
              tri_last  <= 1'b0;
              remaining <= remaining - CNT_W'(1'b1);
              if (remaining == CNT_W'(1'b1)) begin
                state      <= IDLE;
                busy       <= 1'b0;
                frame_done <= 1'b1;
              end else begin
                state    <= LOAD;
                mem_rd   <= 1'b1;
                mem_addr <= rd_ptr;
                req_idx  <= 4'd0;
              end
            end
          end

          default: begin
            state     <= IDLE;
            busy      <= 1'b0;
            mem_rd    <= 1'b0;
            tri_valid <= 1'b0;
            tri_last  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vertex_dispatch.sv
// tb_vertex_dispatch: scoreboard bench for vertex_dispatch. Stimulus pushes
// expected reads, triangles and completions; a negedge monitor pops them.
module tb_vertex_dispatch;
  import gpu_pkg::*;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                cfg_we = 1'b0;
  logic [4:0]          cfg_addr = 5'd0;
  logic [31:0]         cfg_wdata = 32'd0;
  logic                mem_rd;
  logic [23:0]         mem_addr;
  logic [31:0]         mem_rdata = 32'd0;
  logic [15:0][31:0]   mat;
  logic [2:0][31:0]    lighting;
  logic [14:0][31:0]   v_out;
  logic [23:0]         color_out1, color_out2, color_out3;
  logic                tri_valid, tri_last;
  logic                tri_ready = 1'b0;
  logic                busy, frame_done;

  vertex_dispatch #(.ADDR_W(24), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mat(mat), .lighting(lighting), .v_out(v_out),
    .color_out1(color_out1), .color_out2(color_out2), .color_out3(color_out3),
    .tri_valid(tri_valid), .tri_last(tri_last), .tri_ready(tri_ready),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Triangle memory: word at 0x100+j holds j<<16.
  function automatic logic [31:0] exp_word(input int j);
    return 32'(j) << 16;
  endfunction

  always @(posedge clock) begin
    if (mem_rd) mem_rdata <= exp_word(int'(mem_addr) - 256);
  end

  typedef struct { logic [23:0] addr; int cyc; } rd_exp_t;
  typedef struct { int j0; bit last; int cyc; } tri_exp_t;

  rd_exp_t  rd_q[$];
  tri_exp_t tri_q[$];
  int       done_q[$];

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string nm, input logic [63:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h with nothing expected (cyc %0d)", nm, act, cyc);
  endtask

  // Monitor: pops and compares whenever the DUT presents an output.
  rd_exp_t  re;
  tri_exp_t te;
  int       de;
  int       bk;
  bit       tri_seen;

  always @(negedge clock) begin
    if (reset) begin
      tri_seen = 1'b0;
    end else begin
      if (mem_rd) begin
        if (rd_q.size() == 0) note_fail("rd_unexpected", {40'd0, mem_addr});
        else begin
          re = rd_q.pop_front();
          chk("rd_addr", {40'd0, mem_addr}, {40'd0, re.addr});
          if (re.cyc >= 0) chk("rd_cyc", 64'(cyc), 64'(re.cyc));
        end
      end
      if (tri_valid) begin
        if (tri_q.size() == 0) note_fail("tri_unexpected", {63'd0, tri_valid});
        else begin
          te = tri_q[0];
          if (!tri_seen && te.cyc >= 0) chk("tri_valid_cyc", 64'(cyc), 64'(te.cyc));
          tri_seen = 1'b1;
          bk = -1;
          for (int k = 0; k < 15; k++)
            if (bk < 0 && v_out[k] !== exp_word(te.j0 + k)) bk = k;
          if (bk < 0) bk = 0;
          chk("v_out", {32'd0, v_out[bk]}, {32'd0, exp_word(te.j0 + bk)});
          chk("tri_last", {63'd0, tri_last}, {63'd0, te.last});
          if (tri_ready) begin
            chk("color1", {40'd0, color_out1}, {40'd0, exp_word(te.j0 + 3) & 32'h00FF_FFFF});
            chk("color3", {40'd0, color_out3}, {40'd0, exp_word(te.j0 + 11) & 32'h00FF_FFFF});
            void'(tri_q.pop_front());
            tri_seen = 1'b0;
          end
        end
      end
      if (frame_done) begin
        if (done_q.size() == 0) note_fail("done_unexpected", {63'd0, frame_done});
        else begin
          de = done_q.pop_front();
          if (de >= 0) chk("done_cyc", 64'(cyc), 64'(de));
          chk("done_busy", {63'd0, busy}, 64'd0);
        end
      end
    end
  end

  // Host write; returns just after the sampling edge with cyc = cycle T+1.
  task automatic cfg_write(input logic [4:0] a, input logic [31:0] d, output int t);
    @(posedge clock); #1;
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clock); #1;
    t = cyc;
    cfg_we = 1'b0;
  endtask

  // Host write sampled at the end of the cycle whose cyc equals target.
  task automatic cfg_at(input logic [4:0] a, input logic [31:0] d, input int target);
    @(posedge clock); #1;
    while (cyc < target) begin @(posedge clock); #1; end
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clock); #1;
    cfg_we = 1'b0;
  endtask

  // Expected traffic for n triangles from 0x100+j0; t<0 means untimed.
  task automatic push_frame(input int j0, input int n, input int t, input bit done_timed);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 15; k++)
        rd_q.push_back('{24'h100 + 24'(j0 + 15 * i + k), (t >= 0) ? t + 17 * i + k : -1});
      tri_q.push_back('{j0 + 15 * i, (i == n - 1), (t >= 0) ? t + 16 + 17 * i : -1});
    end
    done_q.push_back((t >= 0 && done_timed) ? t + 17 * n : -1);
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    do begin @(posedge clock); #1; n++; end while (!tri_valid && n < max);
    chk("tri_valid_up", {63'd0, tri_valid}, 64'd1);
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    do begin @(posedge clock); #1; n++; end
    while ((busy || rd_q.size() != 0 || tri_q.size() != 0 || done_q.size() != 0) && n < max);
    repeat (3) begin @(posedge clock); #1; end
    chk("queues_empty", 64'(rd_q.size() + tri_q.size() + done_q.size()), 64'd0);
    chk("idle_after", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  int t;

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_mem_rd", {63'd0, mem_rd}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_tri_valid", {63'd0, tri_valid}, 64'd0);
    chk("rst_frame_done", {63'd0, frame_done}, 64'd0);
    chk("rst_mat5", {32'd0, mat[5]}, 64'd0);
    chk("rst_v_out0", {32'd0, v_out[0]}, 64'd0);
    reset = 1'b0;

    // Single triangle, identity matrix
    for (int i = 0; i < 16; i++)
      cfg_write(CFG_MAT0 + 5'(i), (i % 5 == 0) ? 32'h0001_0000 : 32'h0, t);
    cfg_write(CFG_LIGHT0 + 5'd2, 32'h0000_8000, t);
    cfg_write(CFG_BASE, 32'h100, t);
    cfg_write(CFG_COUNT, 32'd1, t);
    chk("mat5_identity", {32'd0, mat[5]}, 64'h0001_0000);
    chk("mat1_zero", {32'd0, mat[1]}, 64'h0);
    chk("light2", {32'd0, lighting[2]}, 64'h0000_8000);
    tri_ready = 1'b0;
    cfg_write(CFG_START, 32'd0, t);
    push_frame(0, 1, t, 1'b0);
    chk("busy_start", {63'd0, busy}, 64'd1);
    wait_valid(40);
    chk("t1_color1", {40'd0, color_out1}, 64'h03_0000);
    chk("t1_color2", {40'd0, color_out2}, 64'h07_0000);
    chk("t1_color3", {40'd0, color_out3}, 64'h0B_0000);
    chk("t1_last", {63'd0, tri_last}, 64'd1);
    tri_ready = 1'b1;
    wait_done(20);

    // Three triangles with ready held high
    cfg_write(CFG_COUNT, 32'd3, t);
    cfg_write(CFG_START, 32'd0, t);
    push_frame(0, 3, t, 1'b1);
    wait_done(100);

    // Backpressure for 40 cycles
    tri_ready = 1'b0;
    cfg_write(CFG_COUNT, 32'd1, t);
    cfg_write(CFG_START, 32'd0, t);
    push_frame(0, 1, t, 1'b0);
    wait_valid(40);
    repeat (40) begin @(posedge clock); #1; end
    chk("bp_valid_held", {63'd0, tri_valid}, 64'd1);
    chk("bp_v_out14", {32'd0, v_out[14]}, 64'h000E_0000);
    tri_ready = 1'b1;
    @(posedge clock); #1;
    chk("bp_accept_same_cycle", {62'd0, tri_valid, frame_done}, 64'b01);
    wait_done(20);

    // Count of zero completes immediately
    cfg_write(CFG_COUNT, 32'd0, t);
    cfg_write(CFG_START, 32'd0, t);
    done_q.push_back(t);
    chk("cnt0_busy", {63'd0, busy}, 64'd0);
    repeat (4) begin @(posedge clock); #1; chk("cnt0_busy", {63'd0, busy}, 64'd0); end
    wait_done(10);

    // Locked matrix write, then abort during LOAD at k=7
    tri_ready = 1'b0;
    cfg_write(CFG_COUNT, 32'd1, t);
    cfg_write(CFG_START, 32'd0, t);
    for (int k = 0; k < 8; k++) rd_q.push_back('{24'h100 + 24'(k), t + k});
    cfg_at(CFG_MAT0 + 5'd5, 32'hDEAD_BEEF, t + 2);
    chk("mat5_locked", {32'd0, mat[5]}, 64'h0001_0000);
    cfg_at(CFG_ABORT, 32'd0, t + 7);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_mem_rd", {63'd0, mem_rd}, 64'd0);
    repeat (25) begin @(posedge clock); #1; end
    chk("abort_reads_done", 64'(rd_q.size()), 64'd0);
    chk("abort_no_valid", {63'd0, tri_valid}, 64'd0);

    // Asynchronous reset while a triangle is presented
    cfg_write(CFG_START, 32'd0, t);
    push_frame(0, 1, t, 1'b0);
    wait_valid(40);
    @(negedge clock); #2;
    reset = 1'b1;
    #1;
    chk("arst_tri_valid", {63'd0, tri_valid}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_mem_rd", {63'd0, mem_rd}, 64'd0);
    chk("arst_v_out0", {32'd0, v_out[0]}, 64'd0);
    chk("arst_color1", {40'd0, color_out1}, 64'd0);
    chk("arst_mat5", {32'd0, mat[5]}, 64'd0);
    rd_q.delete(); tri_q.delete(); done_q.delete();
    @(negedge clock);
    reset = 1'b0;

    // Clean restart from base 0x10F after reset
    tri_ready = 1'b1;
    cfg_write(CFG_BASE, 32'h10F, t);
    cfg_write(CFG_COUNT, 32'd1, t);
    cfg_write(CFG_START, 32'd0, t);
    push_frame(15, 1, t, 1'b1);
    wait_done(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
